icache_param: RTL and testbench

- Parametrised set-associative instruction cache for the RV32IC fetch path, placed between the fetch unit and the byte-serial memory controller.
- Each fetch is split into two halfword lookups, at addr and addr+2, which may fall in different lines.
- New in this generation:
  - configurable ways, sets and line size;
  - the second halfword is skipped when the first halfword is compressed;
  - fetch abort, whole-cache flush, and hit/miss counters.
- Output is raw, not decompressed; the decompressor sits downstream.

---
 rtl/icache_param.sv | 187 ++++++++++++++++++
 tb/tb_icache_param.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_param.sv
// Set-associative instruction cache for the RV32IC fetch path: two halfword lookups per fetch,
// byte-serial line fills, raw (not decompressed) instruction output, abort/flush and hit/miss counters.
module icache_param #(
    parameter int ADDR_W     = 17,
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    input  logic              fetch_abort,
    input  logic              flush,
    output logic              instruction_out_en,
    output logic [31:0]       instruction,
    output logic              c_instruction,
    output logic              memory_get_en,
    output logic [ADDR_W-1:0] memory_addr,
    input  logic              memory_out_en,
    input  logic [7:0]        memory_content,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FILL1, FILL2, RESP} state_t;

    state_t state_q, state_n;

    logic [7:0]       data_q  [WAYS][SETS][LINE_BYTES];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAY_W-1:0] rr_q    [SETS];

    logic [ADDR_W-1:0] a1_q, a2_q, la1, la2, fill_a;
    logic [OFF_W-1:0]  cnt_q, off1, off2, nxt_off;
    logic [IDX_W-1:0]  idx1, idx2, fill_idx;
    logic [TAG_W-1:0]  tag1, tag2, fill_tag;
    logic [WAY_W-1:0]  way1, way2, vic;
    logic              hit1, hit2, vic_found;
    logic [15:0]       hw1, hw2;
    logic              comp, fill_comp, same_line;
    logic [31:0]       asm_instr, instr_q;
    logic              c_q, hit_q;
    logic [LINE_BYTES-1:0][7:0] buf_q, buf_n;
    logic              filling, cancel, last, byte_in, line_done, accept, hit_acc, resp_fire;

    // Lookups run on the incoming address while idle, otherwise on the latched request.
    assign la1  = (state_q == IDLE) ? (fetch_addr & ~ADDR_W'(1)) : a1_q;
    assign la2  = (state_q == IDLE) ? la1 + ADDR_W'(2) : a2_q;
    assign idx1 = la1[OFF_W +: IDX_W];
    assign idx2 = la2[OFF_W +: IDX_W];
    assign tag1 = la1[ADDR_W-1 -: TAG_W];
    assign tag2 = la2[ADDR_W-1 -: TAG_W];
    assign off1 = la1[OFF_W-1:0];
    assign off2 = la2[OFF_W-1:0];

    always_comb begin
        hit1 = 1'b0;
        way1 = '0;
        hit2 = 1'b0;
        way2 = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx1][w] && tag_q[w][idx1] == tag1) begin
                hit1 = 1'b1;
                way1 = WAY_W'(w);
            end
            if (valid_q[idx2][w] && tag_q[w][idx2] == tag2) begin
                hit2 = 1'b1;
                way2 = WAY_W'(w);
            end
        end
    end

    assign hw1 = {data_q[way1][idx1][{off1[OFF_W-1:1], 1'b1}], data_q[way1][idx1][off1]};
    assign hw2 = {data_q[way2][idx2][{off2[OFF_W-1:1], 1'b1}], data_q[way2][idx2][off2]};
    assign comp      = (hw1[1:0] != 2'b11);
    assign asm_instr = comp ? {16'h0000, hw1} : {hw2, hw1};

    assign filling   = (state_q == FILL1) || (state_q == FILL2);
    assign fill_a    = (state_q == FILL1) ? a1_q : a2_q;
    assign fill_idx  = fill_a[OFF_W +: IDX_W];
    assign fill_tag  = fill_a[ADDR_W-1 -: TAG_W];
    assign cancel    = fetch_abort | flush;
    assign last      = &cnt_q;
    assign byte_in   = rst && filling && memory_out_en && !cancel;
    assign line_done = byte_in && last;
    assign accept    = rst && (state_q == IDLE) && fetch_req && !cancel;
    assign hit_acc   = accept && hit1 && (hit2 || comp);
    assign resp_fire = rst && (state_q == RESP) && !cancel;
    assign same_line = (a1_q[ADDR_W-1:OFF_W] == a2_q[ADDR_W-1:OFF_W]);

    always_comb begin
        buf_n = buf_q;
        if (memory_out_en) buf_n[cnt_q] = memory_content;
    end
    // Compressedness is known from the first byte of the halfword, possibly arriving this cycle.
    assign fill_comp = (buf_n[a1_q[OFF_W-1:0]][1:0] != 2'b11);

    always_comb begin
        vic       = rr_q[fill_idx];
        vic_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_q[fill_idx][w]) begin
                vic       = WAY_W'(w);
                vic_found = 1'b1;
            end
        end
    end

    assign nxt_off       = memory_out_en ? cnt_q + OFF_W'(1) : cnt_q;
    assign memory_addr   = (rst && filling) ? {fill_a[ADDR_W-1:OFF_W], nxt_off} : '0;
    assign memory_get_en = rst && filling && !cancel && !(memory_out_en && last);
    assign fetch_ready   = rst && (state_q == IDLE);

    assign instruction_out_en = hit_q | resp_fire;
    assign instruction        = resp_fire ? asm_instr : instr_q;
    assign c_instruction      = resp_fire ? comp : c_q;

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:  if (accept) begin
                       if (!hit1)               state_n = FILL1;
                       else if (!hit2 && !comp) state_n = FILL2;
                   end
            FILL1: if (line_done) state_n = (!fill_comp && !same_line && !hit2) ? FILL2 : RESP;
            FILL2: if (line_done) state_n = RESP;
            RESP:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (cancel) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hit_q      <= 1'b0;
            instr_q    <= '0;
            c_q        <= 1'b0;
            a1_q       <= '0;
            a2_q       <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q <= state_n;
            hit_q   <= hit_acc;
            if (accept) begin
                a1_q <= la1;
                a2_q <= la2;
            end
            if (hit_acc || resp_fire) begin
                instr_q <= asm_instr;
                c_q     <= comp;
            end
            if (hit_acc)   hit_count  <= hit_count + 32'd1;
            if (resp_fire) miss_count <= miss_count + 32'd1;
            if (cancel || accept) cnt_q <= '0;
            else if (byte_in)     cnt_q <= cnt_q + OFF_W'(1);
            if (flush) begin
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end else if (line_done) begin
                valid_q[fill_idx][vic] <= 1'b1;
                rr_q[fill_idx] <= (rr_q[fill_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[fill_idx] + WAY_W'(1);
            end
        end
    end

    // Line bytes collect in a side buffer so an abandoned fill never corrupts a resident line.
    always_ff @(posedge clk) begin
        if (byte_in) buf_q <= buf_n;
        if (line_done) begin
            tag_q[vic][fill_idx] <= fill_tag;
            for (int b = 0; b < LINE_BYTES; b++) data_q[vic][fill_idx][b] <= buf_n[b];
        end
    end
endmodule

// File: tb/tb_icache_param.sv
// Scoreboard bench for icache_param: byte-serial memory responder with random gaps,
// expected instructions queued at issue and compared on each response strobe.
module tb_icache_param;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_ready;
    logic          fetch_abort = 1'b0;
    logic          flush = 1'b0;
    logic          instruction_out_en;
    logic [31:0]   instruction;
    logic          c_instruction;
    logic          memory_get_en;
    logic [AW-1:0] memory_addr;
    logic          memory_out_en;
    logic [7:0]    memory_content;
    logic [31:0]   hit_count, miss_count;

    always #5 clk = ~clk;

    icache_param dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .fetch_abort(fetch_abort), .flush(flush),
        .instruction_out_en(instruction_out_en), .instruction(instruction),
        .c_instruction(c_instruction), .memory_get_en(memory_get_en),
        .memory_addr(memory_addr), .memory_out_en(memory_out_en),
        .memory_content(memory_content), .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct packed { logic [31:0] instr; logic c; } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] log_q[$];
    logic [7:0]    mem [0:(1<<AW)-1];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [31:0]   exp_hit = '0;
    logic [31:0]   exp_miss = '0;

    function automatic exp_t model(input logic [AW-1:0] a);
        logic [AW-1:0] p;
        logic [7:0]    b [4];
        exp_t          e;
        p = {a[AW-1:1], 1'b0};
        for (int i = 0; i < 4; i++) begin
            b[i] = mem[p];
            p = p + AW'(1);
        end
        e.c     = (b[0][1:0] != 2'b11);
        e.instr = e.c ? {16'h0000, b[1], b[0]} : {b[3], b[2], b[1], b[0]};
        return e;
    endfunction

    function automatic bit log_is_range(input logic [AW-1:0] base, input int n);
        bit ok;
        ok = (log_q.size() == n);
        for (int i = 0; i < log_q.size() && ok; i++) ok = (log_q[i] == base + AW'(i));
        return ok;
    endfunction

    // Memory controller: one byte per grant, random idle gaps, drops the request when get_en falls.
    initial begin
        memory_out_en  = 1'b0;
        memory_content = '0;
        forever begin
            @(negedge clk);
            memory_out_en = 1'b0;
            #1;
            if (rst && memory_get_en && $urandom_range(0, 3) != 0) begin
                memory_content = mem[memory_addr];
                log_q.push_back(memory_addr);
                memory_out_en = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst && instruction_out_en) begin
                exp_t e;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_resp got=%h", instruction);
                end else begin
                    e = sb.pop_front();
                    if (instruction !== e.instr || c_instruction !== e.c) begin
                        n_err++;
                        $display("FAIL resp_data got=%h/c%b exp=%h/c%b", instruction, c_instruction, e.instr, e.c);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    task automatic do_fetch(input logic [AW-1:0] a, output int lat);
        int g;
        g = 0;
        while (!fetch_ready && g < 100) begin @(posedge clk); #1; g++; end
        sb.push_back(model(a));
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        lat = 1;
        while (!instruction_out_en && lat < 300) begin @(posedge clk); #1; lat++; end
        if (!instruction_out_en) begin
            n_cmp++; n_err++;
            $display("FAIL fetch_timeout addr=%h", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        n_cmp++;
        if (hit_count !== exp_hit || miss_count !== exp_miss) begin
            n_err++;
            $display("FAIL counters_%s got=%0d/%0d exp=%0d/%0d", tag, hit_count, miss_count, exp_hit, exp_miss);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (fetch_ready !== 1'b0 || instruction_out_en !== 1'b0 || memory_get_en !== 1'b0 || memory_addr !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=rdy%b en%b get%b addr%h exp=0", fetch_ready, instruction_out_en, memory_get_en, memory_addr);
        end
        n_cmp++;
        if (instruction !== 32'h0 || c_instruction !== 1'b0) begin
            n_err++;
            $display("FAIL reset_instr got=%h/%b exp=0", instruction, c_instruction);
        end
        check_counters("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (fetch_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset got=%b exp=1", fetch_ready);
        end
    endtask

    task automatic test_cold_miss();
        int lat;
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
        log_q.delete();
        do_fetch(17'h00000, lat);
        exp_miss++;
        n_cmp++;
        if (!log_is_range(17'h00000, 4)) begin
            n_err++;
            $display("FAIL cold_fill got=%0d bytes exp=4 from 0", log_q.size());
        end
        n_cmp++;
        if (instruction !== 32'h00000513 || c_instruction !== 1'b0) begin
            n_err++;
            $display("FAIL cold_instr got=%h/%b exp=00000513/0", instruction, c_instruction);
        end
        check_counters("cold");
        log_q.delete();
        do_fetch(17'h00000, lat);
        exp_hit++;
        n_cmp++;
        if (lat != 1 || log_q.size() != 0) begin
            n_err++;
            $display("FAIL hit_latency got=%0d/%0d bytes exp=1/0", lat, log_q.size());
        end
        check_counters("hit");
    endtask

    task automatic test_straddle();
        int lat;
        pulse_flush();
        mem[2] = 8'h37; mem[3] = 8'h05; mem[4] = 8'hab; mem[5] = 8'hcd;
        mem[6] = 8'h01; mem[7] = 8'h45;
        log_q.delete();
        do_fetch(17'h00002, lat);
        exp_miss++;
        n_cmp++;
        if (!log_is_range(17'h00000, 8)) begin
            n_err++;
            $display("FAIL straddle_fill got=%0d bytes exp=8 from 0", log_q.size());
        end
        n_cmp++;
        if (instruction !== 32'hcdab0537) begin
            n_err++;
            $display("FAIL straddle_instr got=%h exp=cdab0537", instruction);
        end
        check_counters("straddle");
    endtask

    task automatic test_compressed();
        int lat;
        pulse_flush();
        log_q.delete();
        do_fetch(17'h00006, lat);
        exp_miss++;
        n_cmp++;
        if (!log_is_range(17'h00004, 4)) begin
            n_err++;
            $display("FAIL compressed_fill got=%0d bytes exp=4 from 4", log_q.size());
        end
        n_cmp++;
        if (instruction !== 32'h00004501 || c_instruction !== 1'b1) begin
            n_err++;
            $display("FAIL compressed_instr got=%h/%b exp=00004501/1", instruction, c_instruction);
        end
        check_counters("compressed");
    endtask

    task automatic test_replace();
        int lat;
        pulse_flush();
        do_fetch(17'h00000, lat); exp_miss++;
        do_fetch(17'h00200, lat); exp_miss++;
        do_fetch(17'h00400, lat); exp_miss++;
        log_q.delete();
        do_fetch(17'h00200, lat);
        exp_hit++;
        n_cmp++;
        if (lat != 1 || log_q.size() != 0) begin
            n_err++;
            $display("FAIL replace_b_hit got=%0d/%0d bytes exp=1/0", lat, log_q.size());
        end
        log_q.delete();
        do_fetch(17'h00400, lat);
        exp_hit++;
        n_cmp++;
        if (lat != 1 || log_q.size() != 0) begin
            n_err++;
            $display("FAIL replace_c_hit got=%0d/%0d bytes exp=1/0", lat, log_q.size());
        end
        log_q.delete();
        do_fetch(17'h00000, lat);
        exp_miss++;
        n_cmp++;
        if (!log_is_range(17'h00000, 4)) begin
            n_err++;
            $display("FAIL replace_a_miss got=%0d bytes exp=4 from 0", log_q.size());
        end
        check_counters("replace");
    endtask

    task automatic test_abort();
        int g, lat;
        pulse_flush();
        log_q.delete();
        g = 0;
        while (!fetch_ready && g < 100) begin @(posedge clk); #1; g++; end
        fetch_req  = 1'b1;
        fetch_addr = 17'h00010;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        g = 0;
        while (log_q.size() < 2 && g < 100) begin @(posedge clk); #1; g++; end
        fetch_abort = 1'b1;
        #1;
        n_cmp++;
        if (memory_get_en !== 1'b0) begin
            n_err++;
            $display("FAIL abort_get_en got=%b exp=0", memory_get_en);
        end
        @(posedge clk); #1;
        fetch_abort = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (log_q.size() != 2 || fetch_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_idle got=%0d bytes rdy%b exp=2 rdy1", log_q.size(), fetch_ready);
        end
        check_counters("abort");
        log_q.delete();
        do_fetch(17'h00010, lat);
        exp_miss++;
        n_cmp++;
        if (!log_is_range(17'h00010, 4)) begin
            n_err++;
            $display("FAIL abort_refill got=%0d bytes exp=4 from 10", log_q.size());
        end
        check_counters("refetch");
    endtask

    task automatic test_flush();
        int lat;
        pulse_flush();
        do_fetch(17'h00000, lat); exp_miss++;
        do_fetch(17'h00000, lat); exp_hit++;
        log_q.delete();
        fetch_req  = 1'b1;
        fetch_addr = 17'h00000;
        pulse_flush();
        fetch_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (log_q.size() != 0) begin
            n_err++;
            $display("FAIL flush_blocks_req got=%0d bytes exp=0", log_q.size());
        end
        check_counters("flush");
        do_fetch(17'h00000, lat);
        exp_miss++;
        n_cmp++;
        if (!log_is_range(17'h00000, 4)) begin
            n_err++;
            $display("FAIL flush_refill got=%0d bytes exp=4 from 0", log_q.size());
        end
        check_counters("post_flush");
    endtask

    task automatic test_back_to_back();
        int lat, g;
        do_fetch(17'h00004, lat); exp_miss++;
        g = 0;
        while (!fetch_ready && g < 100) begin @(posedge clk); #1; g++; end
        sb.push_back(model(17'h00000));
        fetch_req  = 1'b1;
        fetch_addr = 17'h00000;
        @(posedge clk); #1;
        n_cmp++;
        if (instruction_out_en !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first got=%b exp=1", instruction_out_en);
        end
        sb.push_back(model(17'h00004));
        fetch_addr = 17'h00004;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        n_cmp++;
        if (instruction_out_en !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second got=%b exp=1", instruction_out_en);
        end
        exp_hit += 2;
        @(posedge clk); #1;
        check_counters("b2b");
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        test_reset();
        test_cold_miss();
        test_straddle();
        test_compressed();
        test_replace();
        test_abort();
        test_flush();
        test_back_to_back();
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
